// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID latch and instruction-memory
// request port, with wait-state handling and stale-response discard.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   pc_pause, ii_pause    hold requests from the pause unit
//   br_valid, br_target   redirect request and address from ID
//   imem_req, imem_addr   fetch request and address
//   imem_rdata            fetched word, valid while imem_ready=1
//   imem_ready            response strobe (may arrive in the request cycle)
//   id_inst, id_pc        IF/ID instruction and its fetch address + 1
//   id_valid              IF/ID holds a real instruction
module fetch_stage #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(16'h0800)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_pause,
    input  logic              ii_pause,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              imem_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic              id_valid
);

    typedef enum logic {
        REQ  = 1'b0,
        DROP = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] drop_addr;
    logic [ADDR_W-1:0] pc_inc;
    logic              stall;
    logic              redir;
    logic              accept;

    // ii_pause alone still freezes the PC: the front end never runs
    // ahead of a held IF/ID latch.
    assign stall  = pc_pause | ii_pause;
    assign redir  = br_valid & ~pc_pause;
    assign accept = imem_ready & (state == REQ);
    assign pc_inc = pc + ADDR_W'(1);

    // In DROP the address of the abandoned fetch stays on the bus so the
    // memory sees a stable request until it answers.
    assign imem_req  = ~rst;
    assign imem_addr = (state == DROP) ? drop_addr : pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= REQ;
            pc        <= RESET_PC;
            drop_addr <= '0;
            id_inst   <= NOP_INST;
            id_pc     <= '0;
            id_valid  <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (redir) begin
                        pc       <= br_target;
                        id_inst  <= NOP_INST;
                        id_valid <= 1'b0;
                        // Fetch still in flight: remember it and discard
                        // its response when it eventually arrives.
                        if (!imem_ready) begin
                            drop_addr <= pc;
                            state     <= DROP;
                        end
                    end else if (stall) begin
                        // Hold everything; accepted data is refetched.
                    end else if (accept) begin
                        pc       <= pc_inc;
                        id_inst  <= imem_rdata;
                        id_pc    <= pc_inc;
                        id_valid <= 1'b1;
                    end else begin
                        id_inst  <= NOP_INST;
                        id_valid <= 1'b0;
                    end
                end
                DROP: begin
                    if (imem_ready) begin
                        state <= REQ;
                    end
                    if (redir) begin
                        pc <= br_target;
                    end
                    if (!stall) begin
                        id_inst  <= NOP_INST;
                        id_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized traffic compared against a behavioural reference model.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        pc_pause;
    logic        ii_pause;
    logic        br_valid;
    logic [15:0] br_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [15:0] id_inst;
    logic [15:0] id_pc;
    logic        id_valid;

    int checks;
    int failures;

    // Reference model state
    logic [15:0] m_pc;
    logic        m_stale;
    logic [15:0] m_stale_addr;
    logic [15:0] m_inst;
    logic [15:0] m_ipc;
    logic        m_valid;

    logic        prev_wait;
    logic [15:0] prev_addr;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .pc_pause   (pc_pause),
        .ii_pause   (ii_pause),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_valid   (id_valid)
    );

    // Memory contents are a fixed function of the address.
    assign imem_rdata = 16'h1000 | imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc         = 16'h0000;
        m_stale      = 1'b0;
        m_stale_addr = 16'h0000;
        m_inst       = 16'h0800;
        m_ipc        = 16'h0000;
        m_valid      = 1'b0;
    endtask

    task automatic bubble();
        m_inst  = 16'h0800;
        m_valid = 1'b0;
    endtask

    // Apply one clock of the fetch rules to the model.
    task automatic model_clock();
        bit take_br;
        bit hold;
        take_br = br_valid && !pc_pause;
        hold    = pc_pause || ii_pause;
        if (rst) begin
            model_reset();
        end else if (m_stale) begin
            if (imem_ready) m_stale = 1'b0;
            if (take_br) m_pc = br_target;
            if (!hold) bubble();
        end else if (take_br) begin
            if (!imem_ready) begin
                m_stale      = 1'b1;
                m_stale_addr = m_pc;
            end
            m_pc = br_target;
            bubble();
        end else if (hold) begin
        end else if (imem_ready) begin
            m_inst  = 16'h1000 | m_pc;
            m_pc    = m_pc + 16'd1;
            m_ipc   = m_pc;
            m_valid = 1'b1;
        end else begin
            bubble();
        end
    endtask

    // Compare DUT to model mid-cycle, then advance one clock.
    task automatic step();
        @(negedge clk);
        chk("req", {15'd0, imem_req}, {15'd0, !rst});
        if (!rst) begin
            chk("addr", imem_addr, m_stale ? m_stale_addr : m_pc);
        end
        if (prev_wait && !rst) begin
            chk("addr_stable", imem_addr, prev_addr);
        end
        chk("id_inst", id_inst, m_inst);
        chk("id_pc", id_pc, m_ipc);
        chk("id_valid", {15'd0, id_valid}, {15'd0, m_valid});
        prev_wait = !rst && !imem_ready;
        prev_addr = imem_addr;
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic pp, input logic ip,
                          input logic bv, input logic [15:0] bt,
                          input logic rdy);
        rst        = r;
        pc_pause   = pp;
        ii_pause   = ip;
        br_valid   = bv;
        br_target  = bt;
        imem_ready = rdy;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        prev_wait = 1'b0;
        prev_addr = 16'h0000;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_valid", {15'd0, id_valid}, 16'd0);
        chk("rst_inst", id_inst, 16'h0800);
        chk("rst_pc", id_pc, 16'h0000);
        step();

        // Zero-wait stream
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        #1;
        chk("s1_addr0", imem_addr, 16'h0000);
        chk("s1_req", {15'd0, imem_req}, 16'd1);
        step();
        chk("s1_inst0", id_inst, 16'h1000);
        chk("s1_pc0", id_pc, 16'h0001);
        chk("s1_addr1", imem_addr, 16'h0001);
        step();
        chk("s1_inst1", id_inst, 16'h1001);
        chk("s1_pc1", id_pc, 16'h0002);
        step();
        chk("s1_inst2", id_inst, 16'h1002);
        chk("s1_addr3", imem_addr, 16'h0003);

        // Wait states at pc=3
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("s3_addr", imem_addr, 16'h0003);
            chk("s3_valid", {15'd0, id_valid}, 16'd0);
            chk("s3_inst", id_inst, 16'h0800);
        end
        imem_ready = 1'b1;
        step();
        chk("s3_inst", id_inst, 16'h1003);
        chk("s3_pc", id_pc, 16'h0004);
        step();
        chk("s2_addr5", imem_addr, 16'h0005);

        // Pause at pc=5
        pc_pause = 1'b1;
        ii_pause = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("s2_addr", imem_addr, 16'h0005);
            chk("s2_hold_pc", id_pc, 16'h0005);
            chk("s2_hold_inst", id_inst, 16'h1004);
        end
        pc_pause = 1'b0;
        ii_pause = 1'b0;
        step();
        chk("s2_inst", id_inst, 16'h1005);
        chk("s2_pc", id_pc, 16'h0006);
        step();
        step();
        chk("s4_addr8", imem_addr, 16'h0008);

        // Zero-wait redirect at pc=8
        br_valid  = 1'b1;
        br_target = 16'h0040;
        step();
        chk("s4_addr", imem_addr, 16'h0040);
        chk("s4_valid", {15'd0, id_valid}, 16'd0);
        br_valid = 1'b0;
        step();
        chk("s4_inst", id_inst, 16'h1040);
        chk("s4_pc", id_pc, 16'h0041);

        // Redirect during a wait at pc=8
        br_valid  = 1'b1;
        br_target = 16'h0008;
        step();
        imem_ready = 1'b0;
        br_target  = 16'h0020;
        step();
        chk("s5_addr_hold", imem_addr, 16'h0008);
        br_valid = 1'b0;
        step();
        chk("s5_addr_hold2", imem_addr, 16'h0008);
        imem_ready = 1'b1;
        step();
        chk("s5_addr", imem_addr, 16'h0020);
        chk("s5_valid", {15'd0, id_valid}, 16'd0);
        step();
        chk("s5_inst", id_inst, 16'h1020);
        chk("s5_pc", id_pc, 16'h0021);

        // Reset while in DROP
        imem_ready = 1'b0;
        br_valid   = 1'b1;
        br_target  = 16'h0030;
        step();
        chk("s6_drop_addr", imem_addr, 16'h0021);
        br_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("s6_req", {15'd0, imem_req}, 16'd0);
        step();
        chk("s6_valid", {15'd0, id_valid}, 16'd0);
        rst        = 1'b0;
        imem_ready = 1'b1;
        #1;
        chk("s6_addr0", imem_addr, 16'h0000);
        step();
        chk("s6_inst", id_inst, 16'h1000);

        // Wrap at 0xFFFF
        br_valid  = 1'b1;
        br_target = 16'hFFFF;
        step();
        chk("wrap_addr", imem_addr, 16'hFFFF);
        br_valid = 1'b0;
        step();
        chk("wrap_inst", id_inst, 16'hFFFF);
        chk("wrap_pc", id_pc, 16'h0000);
        chk("wrap_next", imem_addr, 16'h0000);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(0, 59) == 0,
                   $urandom_range(0, 4) == 0,
                   $urandom_range(0, 5) == 0,
                   $urandom_range(0, 6) == 0,
                   16'($urandom),
                   $urandom_range(0, 9) < 7);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
